// File: rtl/moore_fsm_seq_ctrl.sv
// Command sequencer for the moore_fsm datapath: steps the FSM one pattern bit per cycle and
// returns the captured Moore outputs plus final state. Define MFSM_SEQ_CMP_EN to add expected-output compare.
module moore_fsm_seq_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [MAX_LEN-1:0] i_cmd_pattern,
    input  logic [CNT_W-1:0]   i_cmd_len,
`ifdef MFSM_SEQ_CMP_EN
    input  logic [MAX_LEN-1:0] i_cmd_expect,
    output logic               o_rsp_mismatch,
    output logic [CNT_W-1:0]   o_rsp_err_idx,
`endif
    output logic               o_fsm_en,
    output logic               o_fsm_input,
    input  logic               i_fsm_output,
    input  logic [2:0]         i_fsm_state,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [MAX_LEN-1:0] o_rsp_outputs,
    output logic [2:0]         o_rsp_final_state,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [MAX_LEN-1:0] ONE = MAX_LEN'(1);

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   eff_len;
    logic               accept;
    logic               last_step;
    logic               next_bit;
    logic [MAX_LEN-1:0] capture;

    assign accept    = (state == IDLE) && i_cmd_valid;
    assign eff_len   = (i_cmd_len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : i_cmd_len;
    assign last_step = (idx == len - CNT_W'(1));
    assign idx_nxt   = idx + CNT_W'(1);
    assign next_bit  = |(pattern & (ONE << idx_nxt));
    assign capture   = {{(MAX_LEN-1){1'b0}}, i_fsm_output} << idx;

    // The FSM holds in RESP, so its live state is the stable final state.
    assign o_rsp_final_state = i_fsm_state;

    always_ff @(posedge clk) begin
        if (accept) begin
            pattern <= i_cmd_pattern;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            o_cmd_ready   <= 1'b1;
            o_fsm_en      <= 1'b0;
            o_fsm_input   <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_outputs <= '0;
            o_busy        <= 1'b0;
            idx           <= '0;
            len           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_rsp_outputs <= '0;
                        len           <= eff_len;
                        idx           <= '0;
                        o_cmd_ready   <= 1'b0;
                        o_busy        <= 1'b1;
                        if (eff_len == '0) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                        end else begin
                            state       <= RUN;
                            o_fsm_en    <= 1'b1;
                            o_fsm_input <= i_cmd_pattern[0];
                        end
                    end
                end
                RUN: begin
                    // The FSM advances on this same edge; capture the output of the state it leaves.
                    o_rsp_outputs <= o_rsp_outputs | capture;
                    if (last_step) begin
                        state       <= RESP;
                        o_fsm_en    <= 1'b0;
                        o_fsm_input <= 1'b0;
                        o_rsp_valid <= 1'b1;
                    end else begin
                        idx         <= idx_nxt;
                        o_fsm_input <= next_bit;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_cmd_ready <= 1'b1;
                    o_fsm_en    <= 1'b0;
                    o_fsm_input <= 1'b0;
                    o_rsp_valid <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MFSM_SEQ_CMP_EN
    logic [MAX_LEN-1:0] exp_pat;
    logic               found;
    logic [CNT_W-1:0]   first_idx;

    always_ff @(posedge clk) begin
        if (accept) begin
            exp_pat <= i_cmd_expect;
        end
    end

    always_comb begin
        found     = 1'b0;
        first_idx = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if ((k < int'(len)) && (o_rsp_outputs[k] != exp_pat[k]) && !found) begin
                found     = 1'b1;
                first_idx = CNT_W'(k);
            end
        end
    end

    // Gating by o_rsp_valid keeps both results at 0 outside a live response.
    assign o_rsp_mismatch = o_rsp_valid & found;
    assign o_rsp_err_idx  = o_rsp_valid ? first_idx : '0;
`endif

endmodule

// File: tb/tb_moore_fsm_seq_ctrl.sv
// Bench for moore_fsm_seq_ctrl: drives directed and random commands into the controller
// wrapped around a behavioural moore_fsm, predicting each response from the FSM transition table.
module tb_moore_fsm_seq_ctrl;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_pattern;
    logic [4:0]  cmd_len;
    logic        fsm_en;
    logic        fsm_input;
    logic        fsm_output;
    logic [2:0]  fsm_state;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_outputs;
    logic [2:0]  rsp_final_state;
    logic        busy;
    logic        fsm_load;
`ifdef MFSM_SEQ_CMP_EN
    logic [15:0] cmd_expect;
    logic        rsp_mismatch;
    logic [4:0]  rsp_err_idx;
    logic        e_mis;
    logic [4:0]  e_idx;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [2:0]  model_state;
    logic [15:0] e_out;
    logic [2:0]  e_fin;
    int          e_len;

    always #5 clk = ~clk;

    moore_fsm_seq_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_cmd_valid       (cmd_valid),
        .o_cmd_ready       (cmd_ready),
        .i_cmd_pattern     (cmd_pattern),
        .i_cmd_len         (cmd_len),
`ifdef MFSM_SEQ_CMP_EN
        .i_cmd_expect      (cmd_expect),
        .o_rsp_mismatch    (rsp_mismatch),
        .o_rsp_err_idx     (rsp_err_idx),
`endif
        .o_fsm_en          (fsm_en),
        .o_fsm_input       (fsm_input),
        .i_fsm_output      (fsm_output),
        .i_fsm_state       (fsm_state),
        .o_rsp_valid       (rsp_valid),
        .i_rsp_ready       (rsp_ready),
        .o_rsp_outputs     (rsp_outputs),
        .o_rsp_final_state (rsp_final_state),
        .o_busy            (busy)
    );

    // moore_fsm: U=0 V=1 W=2 X=3 Y=4 Z=5
    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd4 : 3'd1;
            3'd1:    return b ? 3'd0 : 3'd2;
            3'd2:    return b ? 3'd1 : 3'd3;
            3'd3:    return b ? 3'd2 : 3'd5;
            3'd4:    return b ? 3'd3 : 3'd0;
            3'd5:    return b ? 3'd4 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic fsm_out(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd5);
    endfunction

    always @(posedge clk) begin
        if (fsm_load) fsm_state <= 3'd0;
        else if (fsm_en) fsm_state <= fsm_next(fsm_state, fsm_input);
    end
    assign fsm_output = fsm_out(fsm_state);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic [15:0] pat, input logic [4:0] len);
        logic [2:0] s;
        s = model_state;
        e_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        e_out = '0;
        for (int k = 0; k < e_len; k++) begin
            e_out[k] = fsm_out(s);
            s = fsm_next(s, pat[k]);
        end
        e_fin = s;
`ifdef MFSM_SEQ_CMP_EN
        e_mis = 1'b0;
        e_idx = '0;
        for (int k = e_len - 1; k >= 0; k--) begin
            if (e_out[k] != cmd_expect[k]) begin
                e_mis = 1'b1;
                e_idx = 5'(k);
            end
        end
`endif
    endtask

    // Issues one command and returns once the response is up (or the wait bound expires).
    task automatic start_cmd(input logic [15:0] pat, input logic [4:0] len);
        int cycles;
        int steps;
        predict(pat, len);
        @(negedge clk);
        check("start_state", 32'(fsm_state), 32'(model_state));
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_pattern = pat;
        cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_pattern = 16'($urandom);
        cmd_len = 5'($urandom);
`ifdef MFSM_SEQ_CMP_EN
        cmd_expect = 16'($urandom);
`endif
        cycles = 1;
        steps = 0;
        while (!rsp_valid && cycles < 40) begin
            if (fsm_en) steps++;
            @(negedge clk);
            cycles++;
        end
        check("rsp_latency", 32'(cycles), 32'((e_len == 0) ? 1 : e_len + 1));
        check("fsm_steps", 32'(steps), 32'(e_len));
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_outputs", 32'(rsp_outputs), 32'(e_out));
        check("final_state", 32'(rsp_final_state), 32'(e_fin));
        check("busy_resp", 32'(busy), 32'd1);
        check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
        check("fsm_en_resp", 32'(fsm_en), 32'd0);
`ifdef MFSM_SEQ_CMP_EN
        check("rsp_mismatch", 32'(rsp_mismatch), 32'(e_mis));
        check("rsp_err_idx", 32'(rsp_err_idx), 32'(e_idx));
`endif
    endtask

    task automatic hold_resp(input int n);
        for (int h = 0; h < n; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_outputs", 32'(rsp_outputs), 32'(e_out));
            check("hold_final", 32'(rsp_final_state), 32'(e_fin));
            check("hold_fsm_state", 32'(fsm_state), 32'(e_fin));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
    endtask

    task automatic finish_cmd();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        model_state = e_fin;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        cmd_valid = 1'b0;
        cmd_pattern = '0;
        cmd_len = '0;
        rsp_ready = 1'b0;
        fsm_load = 1'b1;
`ifdef MFSM_SEQ_CMP_EN
        cmd_expect = '0;
`endif
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_fsm_en", 32'(fsm_en), 32'd0);
        check("rst_fsm_input", 32'(fsm_input), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_outputs", 32'(rsp_outputs), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_final_follows", 32'(rsp_final_state), 32'd0);
        fsm_load = 1'b0;
        rst = 1'b1;
        model_state = 3'd0;

        // T1 (expect also drives the compare case when enabled)
`ifdef MFSM_SEQ_CMP_EN
        cmd_expect = 16'h0003;
`endif
        start_cmd(16'h0000, 5'd4);
        check("t1_outputs", 32'(rsp_outputs), 32'h0007);
        check("t1_final", 32'(rsp_final_state), 32'd5);
`ifdef MFSM_SEQ_CMP_EN
        check("t6_mismatch", 32'(rsp_mismatch), 32'd1);
        check("t6_err_idx", 32'(rsp_err_idx), 32'd2);
`endif
        finish_cmd();

        // T2
        start_cmd(16'h0003, 5'd2);
        check("t2_outputs", 32'(rsp_outputs), 32'h0001);
        check("t2_final", 32'(rsp_final_state), 32'd3);
        finish_cmd();

        // T3: zero length
        start_cmd(16'($urandom), 5'd0);
        check("t3_outputs", 32'(rsp_outputs), 32'd0);
        check("t3_final", 32'(rsp_final_state), 32'd3);
        finish_cmd();

        // T4: back-pressure on the response
        start_cmd(16'h00a5, 5'd6);
        hold_resp(5);
        finish_cmd();

        // T5: over-long length clamps to MAX_LEN
        start_cmd(16'($urandom), 5'd31);
        check("t5_steps_clamped", 32'(e_len), 32'd16);
        finish_cmd();

        // T5: reset after three steps of a command
        pat = 16'($urandom);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_pattern = pat;
        cmd_len = 5'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_bit0", 32'(fsm_input), 32'(pat[0]));
        repeat (3) @(negedge clk);
        check("abort_bit3", 32'(fsm_input), 32'(pat[3]));
        rst = 1'b0;
        #1;
        check("abort_fsm_en", 32'(fsm_en), 32'd0);
        check("abort_fsm_input", 32'(fsm_input), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_outputs", 32'(rsp_outputs), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 3; k++) model_state = fsm_next(model_state, pat[k]);
        @(negedge clk);
        check("abort_fsm_kept", 32'(fsm_state), 32'(model_state));
        rst = 1'b1;

`ifdef MFSM_SEQ_CMP_EN
        // T6: matching expectation from U
        fsm_load = 1'b1;
        @(negedge clk);
        fsm_load = 1'b0;
        model_state = 3'd0;
        cmd_expect = 16'h0007;
        start_cmd(16'h0000, 5'd4);
        check("t6_no_mismatch", 32'(rsp_mismatch), 32'd0);
        finish_cmd();
`endif

        // Random commands
        for (int n = 0; n < 12; n++) begin
`ifdef MFSM_SEQ_CMP_EN
            cmd_expect = 16'($urandom);
`endif
            start_cmd(16'($urandom), 5'($urandom_range(0, 20)));
            hold_resp(int'($urandom_range(0, 2)));
            finish_cmd();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
